// File: rtl/spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_encoder
// Purpose  : Rate-coding spike source. Streams TIMESTEPS spike vectors per
//            frame from a loadable per-synapse intensity table. The macro
//            SPIKE_ENCODER_DETERMINISTIC_EN selects phase-accumulator coding
//            instead of the LFSR stochastic coding.
// Revision : 1.0  initial release
// ============================================================================
module spike_encoder #(
    parameter int          SYNAPSES       = 32,
    parameter int          INTENSITY_BITS = 4,
    parameter int          TIMESTEPS      = 16,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [$clog2(SYNAPSES)-1:0] load_index,
    input  logic [INTENSITY_BITS-1:0]   load_value,
    input  logic                        start,
    output logic                        busy,
    output logic [SYNAPSES-1:0]         spikes,
    output logic                        spikes_valid,
    input  logic                        spikes_ready,
    output logic [15:0]                 timestep,
    output logic                        done
);
    localparam int c_IDX_W = $clog2(SYNAPSES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [15:0]               ts_q, ts_d;
    logic [INTENSITY_BITS-1:0] intens_q [SYNAPSES];
    logic [INTENSITY_BITS-1:0] intens_d [SYNAPSES];
    logic                      go;
    logic                      xfer;
    logic [SYNAPSES-1:0]       spk;

    assign go   = (state_q == S_IDLE) && start;
    assign xfer = (state_q == S_RUN) && spikes_ready;

    always_comb begin
        state_d  = state_q;
        ts_d     = ts_q;
        intens_d = intens_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    ts_d    = 16'd0;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (ts_q == 16'(TIMESTEPS - 1)) begin
                        state_d = S_DONE;
                        ts_d    = 16'd0;
                    end else begin
                        ts_d = ts_q + 16'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Out-of-range indices only exist when SYNAPSES is not a power of two.
        if (load_valid && (state_q == S_IDLE) &&
            ({1'b0, load_index} < (c_IDX_W + 1)'(SYNAPSES))) begin
            intens_d[load_index] = load_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ts_q     <= 16'd0;
            intens_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_d;
            intens_q <= intens_d;
        end
    end

`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
    logic [INTENSITY_BITS-1:0] acc_q   [SYNAPSES];
    logic [INTENSITY_BITS-1:0] acc_d   [SYNAPSES];
    logic [INTENSITY_BITS:0]   acc_sum [SYNAPSES];

    // A spike is the carry out of the phase accumulator.
    always_comb begin
        for (int i = 0; i < SYNAPSES; i++) begin
            acc_sum[i] = {1'b0, acc_q[i]} + {1'b0, intens_q[i]};
            spk[i]     = acc_sum[i][INTENSITY_BITS];
            if (go) begin
                acc_d[i] = '0;
            end else if (xfer) begin
                acc_d[i] = acc_sum[i][INTENSITY_BITS-1:0];
            end else begin
                acc_d[i] = acc_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '{default: '0};
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] lfsr_dbl;

    // Doubling the LFSR turns a left rotation into a plain part-select.
    always_comb begin
        lfsr_dbl = {lfsr_q, lfsr_q};
        lfsr_d   = lfsr_q;
        if (go) begin
            lfsr_d = LFSR_SEED;
        end else if (xfer) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
        for (int i = 0; i < SYNAPSES; i++) begin
            spk[i] = intens_q[i] > lfsr_dbl[(16 - (i % 16)) +: INTENSITY_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign load_ready   = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign spikes_valid = (state_q == S_RUN);
    assign done         = (state_q == S_DONE);
    assign timestep     = ts_q;
    assign spikes       = spikes_valid ? spk : '0;

endmodule
`default_nettype wire

// File: tb/tb_spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_encoder
// Purpose  : Randomized self-checking bench for spike_encoder against a
//            frame-level reference model (LFSR or phase-accumulator coding).
// Revision : 1.0  initial release
// ============================================================================
module tb_spike_encoder;
    localparam int SYN  = 32;
    localparam int TS   = 16;
    localparam int SEED = 'hACE1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic [4:0]     load_index = '0;
    logic [3:0]     load_value = '0;
    logic           start = 1'b0;
    logic           busy;
    logic [SYN-1:0] spikes;
    logic           spikes_valid;
    logic           spikes_ready = 1'b0;
    logic [15:0]    timestep;
    logic           done;

    spike_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_index   (load_index),
        .load_value   (load_value),
        .start        (start),
        .busy         (busy),
        .spikes       (spikes),
        .spikes_valid (spikes_valid),
        .spikes_ready (spikes_ready),
        .timestep     (timestep),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int             m_i   [SYN];
    int             m_acc [SYN];
    int             m_lfsr;
    int             m_ts;
    logic [SYN-1:0] cur_trace [TS];
    logic [SYN-1:0] trace_a   [TS];
    int             cnt1, cnt3, cnt4;

    function automatic logic [SYN-1:0] model_vec();
        logic [SYN-1:0] v;
        int k, rot;
        for (int i = 0; i < SYN; i++) begin
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
            v[i] = (m_acc[i] + m_i[i]) >= 16;
`else
            k    = i % 16;
            rot  = ((m_lfsr << k) | (m_lfsr >> (16 - k))) & 'hFFFF;
            v[i] = m_i[i] > (rot % 16);
`endif
        end
        return v;
    endfunction

    function automatic void model_step();
        int fb;
        for (int i = 0; i < SYN; i++) m_acc[i] = (m_acc[i] + m_i[i]) % 16;
        fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
        m_ts++;
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_load_ready"}, load_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_valid"}, spikes_valid, 0);
        check_eq({tag, "_spikes"}, spikes, 0);
        check_eq({tag, "_timestep"}, timestep, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    // Called #1 after a rising edge.
    task automatic do_load(input int idx, input int val);
        load_valid = 1'b1;
        load_index = 5'(idx);
        load_value = 4'(val);
        @(posedge clk); #1;
        load_valid = 1'b0;
        m_i[idx] = val;
    endtask

    task automatic run_frame(input bit rand_ready, input bit disturb,
                             input bit ld, input int ld_idx, input int ld_val);
        int cyc;
        int sent;
        cnt1 = 0; cnt3 = 0; cnt4 = 0;
        start = 1'b1;
        if (ld) begin
            load_valid = 1'b1;
            load_index = 5'(ld_idx);
            load_value = 4'(ld_val);
        end
        @(posedge clk); #1;
        start      = 1'b0;
        load_valid = 1'b0;
        if (ld) m_i[ld_idx] = ld_val;
        m_lfsr = SEED;
        m_ts   = 0;
        for (int i = 0; i < SYN; i++) m_acc[i] = 0;
        cyc  = 0;
        sent = 0;
        while (sent < TS && cyc < TS * 8) begin
            spikes_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (disturb) begin
                start      = 1'($urandom_range(0, 1));
                load_valid = 1'b1;
                load_index = 5'($urandom_range(0, SYN - 1));
                load_value = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            check_eq("valid", spikes_valid, 1);
            check_eq("timestep", timestep, 64'(m_ts));
            check_eq("spikes", spikes, model_vec());
            check_eq("load_ready_run", load_ready, 0);
            if (spikes_ready && m_ts < TS) begin
                cur_trace[m_ts] = spikes;
                cnt1 += int'(spikes[1]);
                cnt3 += int'(spikes[3]);
                cnt4 += int'(spikes[4]);
            end
            @(posedge clk); #1;
            if (spikes_ready) begin
                model_step();
                sent++;
            end
            cyc++;
        end
        start      = 1'b0;
        load_valid = 1'b0;
        check_eq("frame_vectors", 64'(sent), 64'(TS));
        if (!rand_ready) check_eq("frame_cycles", 64'(cyc), 64'(TS));
        @(negedge clk);
        check_eq("done_pulse", done, 1);
        check_eq("done_valid", spikes_valid, 0);
        check_eq("done_spikes", spikes, 0);
        check_eq("done_busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("post_done", done, 0);
        check_eq("post_load_ready", load_ready, 1);
        check_eq("post_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int dones;
        for (int i = 0; i < SYN; i++) m_i[i] = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;

        for (int i = 0; i < SYN; i++) do_load(i, int'($urandom_range(0, 15)));
        do_load(0, 15);
        do_load(1, 0);
        do_load(3, 8);
        do_load(4, 15);

        run_frame(1'b0, 1'b0, 1'b0, 0, 0);
        trace_a = cur_trace;
        check_eq("zero_intensity_spikes", 64'(cnt1), 0);
`ifdef SPIKE_ENCODER_DETERMINISTIC_EN
        check_eq("det_i8_count", 64'(cnt3), 8);
        check_eq("det_i15_count", 64'(cnt4), 15);
        check_eq("det_i15_t0", trace_a[0][4], 0);
        check_eq("det_i8_t1", trace_a[1][3], 1);
`endif

        run_frame(1'b0, 1'b0, 1'b0, 0, 0);
        for (int t = 0; t < TS; t++) check_eq("repeat_frame", cur_trace[t], trace_a[t]);

        run_frame(1'b1, 1'b0, 1'b0, 0, 0);
        run_frame(1'b1, 1'b1, 1'b0, 0, 0);
        run_frame(1'b0, 1'b0, 1'b1, 5, 11);

        repeat (3) begin
            for (int i = 0; i < SYN; i++) do_load(i, int'($urandom_range(0, 15)));
            run_frame(1'b1, 1'b0, 1'b0, 0, 0);
        end

        // Abort a frame with reset while timestep 5 is presented.
        spikes_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("ts_before_reset", timestep, 5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < SYN; i++) m_i[i] = 0;
        @(negedge clk);
        check_reset_vals("abort");
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("abort_no_done", 64'(dones), 0);
        @(posedge clk); #1;
        run_frame(1'b1, 1'b0, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
